// File: rtl/fifo_to_axis_video.sv
// Drains the test-image pixel FIFO into one AXI4-Stream video frame per enable edge,
// with tuser/tlast framing, an s2mm_fsync pulse and a 2-entry skid buffer.
//
// state  | meaning
// IDLE   | waiting for an enable rising edge; counters and buffer held clear
// FSYNC  | one-cycle s2mm_fsync pulse
// ACTIVE | reading the FIFO and streaming beats
// DONE   | frame complete; waiting for enable to drop
module fifo_to_axis_video #(
  parameter int H_ACTIVE            = 640,
  parameter int V_ACTIVE            = 480,
  parameter int C_M_AXIS_DATA_WIDTH = 24
) (
  input  logic                               m_axis_aclk,
  input  logic                               m_axis_aresetn,
  input  logic                               enable,
  input  logic [31:0]                        fifo_rdata,
  input  logic                               fifo_empty,
  output logic                               fifo_rd,
  output logic                               s2mm_fsync,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tuser,
  output logic                               m_axis_tlast,
  output logic                               frame_done,
  output logic [15:0]                        frame_cnt
);

  localparam int DW   = C_M_AXIS_DATA_WIDTH;
  localparam int XW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int NPIX = H_ACTIVE * V_ACTIVE;
  localparam int RW   = $clog2(NPIX + 1);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [RW-1:0] R_ALL  = RW'(NPIX);

  typedef enum logic [1:0] {IDLE, FSYNC, ACTIVE, DONE} state_t;

  state_t          state;
  logic            enable_q;
  logic [1:0]      occ;
  logic            inflight;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [RW-1:0]   req_cnt;
  logic [DW-1:0]   buf0;
  logic [DW-1:0]   buf1;
  logic            pop;
  logic            push;
  logic [2:0]      level;
  logic [31:0]     rdata_unused;

  // Upper byte of the FIFO word is padding; only the low DW bits carry pixel data.
  assign rdata_unused = fifo_rdata;

  assign m_axis_tvalid = (state == ACTIVE) && (occ != 2'd0);
  assign m_axis_tdata  = buf0;
  assign m_axis_tuser  = m_axis_tvalid && (x == '0) && (y == '0);
  assign m_axis_tlast  = m_axis_tvalid && (x == X_LAST);
  assign m_axis_tstrb  = '1;
  assign s2mm_fsync    = (state == FSYNC);

  // A read is only issued when the word it returns is guaranteed a buffer slot.
  always_comb begin
    pop     = m_axis_tvalid && m_axis_tready;
    push    = inflight && (state == ACTIVE);
    level   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    fifo_rd = (state == ACTIVE) && !fifo_empty && (level < 3'd2) && (req_cnt != R_ALL);
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state      <= IDLE;
      enable_q   <= 1'b0;
      occ        <= 2'd0;
      inflight   <= 1'b0;
      x          <= '0;
      y          <= '0;
      req_cnt    <= '0;
      buf0       <= '0;
      buf1       <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      enable_q   <= enable;
      inflight   <= fifo_rd;
      frame_done <= 1'b0;
      if (fifo_rd) req_cnt <= req_cnt + RW'(1);

      case (state)
        IDLE: begin
          occ     <= 2'd0;
          x       <= '0;
          y       <= '0;
          req_cnt <= '0;
          if (enable && !enable_q) state <= FSYNC;
        end
        FSYNC: begin
          state <= enable ? ACTIVE : IDLE;
        end
        ACTIVE: begin
          if (!enable) begin
            // Abort: drop buffered data; a read still in flight lands in IDLE and is ignored.
            state   <= IDLE;
            occ     <= 2'd0;
            x       <= '0;
            y       <= '0;
            req_cnt <= '0;
          end else begin
            case ({push, pop})
              2'b10: begin
                if (occ == 2'd0) buf0 <= fifo_rdata[DW-1:0];
                else             buf1 <= fifo_rdata[DW-1:0];
                occ <= occ + 2'd1;
              end
              2'b01: begin
                buf0 <= buf1;
                occ  <= occ - 2'd1;
              end
              2'b11: begin
                if (occ == 2'd1) begin
                  buf0 <= fifo_rdata[DW-1:0];
                end else begin
                  buf0 <= buf1;
                  buf1 <= fifo_rdata[DW-1:0];
                end
              end
              default: ;
            endcase

            if (pop) begin
              if (x == X_LAST) begin
                x <= '0;
                if (y == Y_LAST) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
                  frame_cnt  <= frame_cnt + 16'd1;
                end else begin
                  y <= y + YW'(1);
                end
              end else begin
                x <= x + XW'(1);
              end
            end
          end
        end
        DONE: begin
          if (!enable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_to_axis_video.sv
// Scoreboard bench for fifo_to_axis_video on a 4x2 frame: a FIFO model feeds the DUT,
// stimulus queues expected beats, and a negedge monitor pops and compares them.
module tb_fifo_to_axis_video;

  localparam int H = 4;
  localparam int V = 2;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] fifo_rdata;
  logic        fifo_empty;
  logic        fifo_rd;
  logic        fsync;
  logic [23:0] tdata;
  logic [2:0]  tstrb;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;
  logic        frame_done;
  logic [15:0] frame_cnt;

  fifo_to_axis_video #(.H_ACTIVE(H), .V_ACTIVE(V), .C_M_AXIS_DATA_WIDTH(24)) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (rst_n),
    .enable         (enable),
    .fifo_rdata     (fifo_rdata),
    .fifo_empty     (fifo_empty),
    .fifo_rd        (fifo_rd),
    .s2mm_fsync     (fsync),
    .m_axis_tdata   (tdata),
    .m_axis_tstrb   (tstrb),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tuser   (tuser),
    .m_axis_tlast   (tlast),
    .frame_done     (frame_done),
    .frame_cnt      (frame_cnt)
  );

  typedef struct {
    logic [23:0] d;
    logic        u;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] mem [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          rd_cnt = 0;
  logic        flush_req = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int beats_seen = 0, tlast_cnt = 0, fsync_cnt = 0, done_cnt = 0, valid_cyc_cnt = 0;
  int rise_cyc = 0, last_pop_cyc = 0, fsync_cyc = 0;

  int tr_mode = 0;
  int tr_ph   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  assign fifo_empty = (rd_ptr == wr_ptr);

  // FIFO model: registered read data, valid the cycle after fifo_rd.
  initial begin
    fifo_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (flush_req) begin
        rd_ptr <= wr_ptr;
      end else if (fifo_rd) begin
        fifo_rdata <= mem[rd_ptr % 64];
        rd_ptr     <= rd_ptr + 1;
        rd_cnt++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input int tag, input int i);
    logic [31:0] w;
    if (tag == 0) w = 32'h00010101 * (i + 1);
    else          w = {8'(8'hA0 + tag), 8'(tag), 8'(i + 1), 8'(8'hC0 - i)};
    return w;
  endfunction

  // Load n words of a frame into the FIFO; the first nexp of them are expected on the bus.
  task automatic add_words(input int tag, input int start, input int n, input int nexp);
    beat_t       b;
    logic [31:0] w;
    for (int i = start; i < start + n; i++) begin
      w = word_of(tag, i);
      mem[wr_ptr % 64] = w;
      wr_ptr++;
      if (i - start < nexp) begin
        b.d = w[23:0];
        b.u = (i == 0);
        b.l = ((i % H) == H - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    tr_ph++;
    case (tr_mode)
      0:       tready = 1'b1;
      1:       tready = ((tr_ph % 4) == 0) || ((tr_ph % 4) == 3);
      default: tready = 1'b0;
    endcase
  endtask

  task automatic wait_done(input int base, input string name);
    for (int i = 0; i < 300 && done_cnt == base; i++) tick();
    chk(name, 32'(done_cnt - base), 32'd1);
  endtask

  task automatic wait_beats(input int target, input string name);
    for (int i = 0; i < 100 && beats_seen < target; i++) tick();
    chk(name, 32'(beats_seen >= target), 32'd1);
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    beat_t       e;
    logic        prev_stall = 1'b0;
    logic        prev_valid = 1'b0;
    logic [23:0] prev_data  = '0;
    logic        prev_user  = 1'b0;
    logic        prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall) begin
          chk("hold_tvalid", 32'(tvalid), 32'd1);
          chk("hold_tdata",  32'(tdata),  32'(prev_data));
          chk("hold_tuser",  32'(tuser),  32'(prev_user));
          chk("hold_tlast",  32'(tlast),  32'(prev_last));
        end
        if (fifo_rd) chk("rd_while_empty", 32'(fifo_empty), 32'd0);
        chk("occ_bound", 32'((dut.occ + dut.inflight) <= 2), 32'd1);
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got tdata %h, expected no beat", tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat_tdata", 32'(tdata), 32'(e.d));
            chk("beat_tuser", 32'(tuser), 32'(e.u));
            chk("beat_tlast", 32'(tlast), 32'(e.l));
          end
          beats_seen++;
          last_pop_cyc = cyc;
          if (tlast) tlast_cnt++;
        end
        if (tvalid) valid_cyc_cnt++;
        if (tvalid && !prev_valid) rise_cyc = cyc;
        if (fsync) begin
          fsync_cnt++;
          fsync_cyc = cyc;
        end
        if (frame_done) done_cnt++;
        prev_stall = tvalid && !tready && enable;
        prev_valid = tvalid;
        prev_data  = tdata;
        prev_user  = tuser;
        prev_last  = tlast;
      end else begin
        prev_stall = 1'b0;
        prev_valid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_fs, s_dn, s_tl, s_rd, s_vc, base, en_cyc;
    rst_n  = 1'b0;
    enable = 1'b0;
    tready = 1'b0;

    #12;
    chk("rst_tvalid",    32'(tvalid),     32'd0);
    chk("rst_fifo_rd",   32'(fifo_rd),    32'd0);
    chk("rst_fsync",     32'(fsync),      32'd0);
    chk("rst_done",      32'(frame_done), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt),  32'd0);
    chk("rst_tstrb",     32'(tstrb),      32'd7);
    chk("rst_tdata",     32'(tdata),      32'd0);
    chk("rst_tuser",     32'(tuser),      32'd0);
    chk("rst_tlast",     32'(tlast),      32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();

    // Basic frame, tready held high.
    tr_mode = 0;
    add_words(0, 0, 8, 8);
    s_fs = fsync_cnt; s_dn = done_cnt; s_tl = tlast_cnt; s_rd = rd_cnt;
    tick();
    enable = 1'b1;
    en_cyc = cyc;
    wait_done(s_dn, "f1_done");
    repeat (3) tick();
    chk("f1_fsync_pulses",  32'(fsync_cnt - s_fs),         32'd1);
    chk("f1_fsync_cycle",   32'(fsync_cyc - en_cyc),       32'd1);
    chk("f1_first_latency", 32'(rise_cyc - en_cyc),        32'd4);
    chk("f1_throughput",    32'(last_pop_cyc - rise_cyc),  32'd7);
    chk("f1_tlast_count",   32'(tlast_cnt - s_tl),         32'd2);
    chk("f1_fifo_reads",    32'(rd_cnt - s_rd),            32'd8);
    chk("f1_frame_cnt",     32'(frame_cnt),                32'd1);
    chk("f1_all_beats",     32'(exp_q.size()),             32'd0);
    enable = 1'b0;
    repeat (2) tick();

    // Same frame with tready toggling 1-0-0-1.
    tr_mode = 1;
    add_words(2, 0, 8, 8);
    s_dn = done_cnt; s_tl = tlast_cnt; s_rd = rd_cnt;
    tick();
    enable = 1'b1;
    wait_done(s_dn, "f2_done");
    repeat (3) tick();
    chk("f2_tlast_count", 32'(tlast_cnt - s_tl), 32'd2);
    chk("f2_fifo_reads",  32'(rd_cnt - s_rd),    32'd8);
    chk("f2_frame_cnt",   32'(frame_cnt),        32'd2);
    chk("f2_all_beats",   32'(exp_q.size()),     32'd0);
    enable = 1'b0;
    repeat (2) tick();

    // FIFO runs dry after beat 2, then is refilled.
    tr_mode = 0;
    add_words(3, 0, 3, 3);
    s_dn = done_cnt; s_tl = tlast_cnt; s_rd = rd_cnt; base = beats_seen;
    tick();
    enable = 1'b1;
    wait_beats(base + 3, "f3_first_beats");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("f3_empty_tvalid", 32'(tvalid),  32'd0);
      chk("f3_empty_rd",     32'(fifo_rd), 32'd0);
    end
    add_words(3, 3, 5, 5);
    wait_done(s_dn, "f3_done");
    repeat (3) tick();
    chk("f3_tlast_count", 32'(tlast_cnt - s_tl), 32'd2);
    chk("f3_fifo_reads",  32'(rd_cnt - s_rd),    32'd8);
    chk("f3_frame_cnt",   32'(frame_cnt),        32'd3);
    chk("f3_all_beats",   32'(exp_q.size()),     32'd0);
    enable = 1'b0;
    repeat (2) tick();

    // Abort after beat 5, then restart on fresh data.
    tr_mode = 0;
    add_words(4, 0, 8, 6);
    s_dn = done_cnt; base = beats_seen;
    tick();
    enable = 1'b1;
    for (int i = 0; i < 100 && beats_seen < base + 6; i++) tick();
    chk("f4_beats_before_abort", 32'(beats_seen >= base + 6), 32'd1);
    tr_mode = 2;
    tready  = 1'b0;
    enable  = 1'b0;
    repeat (4) tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("f4_abort_no_done",   32'(done_cnt - s_dn),   32'd0);
    chk("f4_abort_frame_cnt", 32'(frame_cnt),         32'd3);
    chk("f4_abort_beats",     32'(beats_seen - base), 32'd6);
    chk("f4_abort_tvalid",    32'(tvalid),            32'd0);
    tr_mode = 0;
    add_words(14, 0, 8, 8);
    s_dn = done_cnt;
    tick();
    enable = 1'b1;
    wait_done(s_dn, "f4_restart_done");
    repeat (3) tick();
    chk("f4_restart_frame_cnt", 32'(frame_cnt),    32'd4);
    chk("f4_restart_all_beats", 32'(exp_q.size()), 32'd0);
    enable = 1'b0;
    repeat (2) tick();

    // enable held after frame_done with extra words waiting.
    add_words(5, 0, 8, 8);
    add_words(6, 0, 3, 3);
    s_dn = done_cnt; s_rd = rd_cnt;
    tick();
    enable = 1'b1;
    wait_done(s_dn, "f5_done");
    s_vc = valid_cyc_cnt;
    repeat (20) tick();
    chk("f5_hold_reads",     32'(rd_cnt - s_rd),        32'd8);
    chk("f5_hold_tvalid",    32'(valid_cyc_cnt - s_vc), 32'd0);
    chk("f5_hold_frame_cnt", 32'(frame_cnt),            32'd5);
    enable = 1'b0;
    repeat (2) tick();
    add_words(6, 3, 5, 5);
    s_dn = done_cnt;
    enable = 1'b1;
    wait_done(s_dn, "f5_second_done");
    repeat (3) tick();
    chk("f5_second_frame_cnt", 32'(frame_cnt),    32'd6);
    chk("f5_second_all_beats", 32'(exp_q.size()), 32'd0);
    enable = 1'b0;
    repeat (2) tick();

    // Asynchronous reset in the middle of a frame.
    add_words(7, 0, 8, 8);
    base = beats_seen;
    tick();
    enable = 1'b1;
    wait_beats(base + 3, "f7_beats_before_reset");
    #1;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    chk("arst_tvalid",    32'(tvalid),     32'd0);
    chk("arst_fifo_rd",   32'(fifo_rd),    32'd0);
    chk("arst_tuser",     32'(tuser),      32'd0);
    chk("arst_tlast",     32'(tlast),      32'd0);
    chk("arst_tdata",     32'(tdata),      32'd0);
    chk("arst_frame_cnt", 32'(frame_cnt),  32'd0);
    chk("arst_tstrb",     32'(tstrb),      32'd7);
    exp_q.delete();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
